// File: rtl/vending_machine_param.sv
// vending_machine_param
//
// Purpose:
//   Parameterised coin-operated vending controller. It accepts one-unit coins
//   up to a credit ceiling and dispenses one of N_ITEMS products when a single
//   product is requested and the credit covers its price. It can also return
//   all remaining credit as a train of one-unit coin pulses, either on request
//   or automatically after every sale when AUTO_CHANGE is set.
//
// Parameters:
//   N_ITEMS     number of selectable products
//   CREDIT_W    width of the credit register and of each price field
//   MAX_CREDIT  credit ceiling in coin units (1..min(99, 2^CREDIT_W-1))
//   PRICES      packed prices, item i in bits [i*CREDIT_W +: CREDIT_W]
//   AUTO_CHANGE 1 = refund leftover credit after every dispense
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   i_coin         one-unit coin insert, sampled every cycle
//   i_sel          product request, accepted only when one-hot
//   i_refund       request return of all credit
//   o_led_avail    bit i high while item i is affordable in CREDIT
//   o_dispense     one-cycle one-hot dispense pulse
//   o_coin_ret     one pulse per returned coin unit
//   o_coin_reject  one-cycle pulse after a coin was not accepted
//   o_credit       current credit, binary
//   o_bcd_tens     credit / 10
//   o_bcd_ones     credit % 10
//   o_busy         high while dispensing or refunding

module vending_machine_param #(
  parameter int                          N_ITEMS     = 4,
  parameter int                          CREDIT_W    = 4,
  parameter int                          MAX_CREDIT  = 9,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES      = {4'd3, 4'd2, 4'd1, 4'd1},
  parameter bit                          AUTO_CHANGE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_coin,
  input  logic [N_ITEMS-1:0]  i_sel,
  input  logic                i_refund,
  output logic [N_ITEMS-1:0]  o_led_avail,
  output logic [N_ITEMS-1:0]  o_dispense,
  output logic                o_coin_ret,
  output logic                o_coin_reject,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [3:0]          o_bcd_tens,
  output logic [3:0]          o_bcd_ones,
  output logic                o_busy
);

  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] ONE_C = CREDIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_REFUND   = 2'd3
  } state_t;

  state_t              state;
  logic [CREDIT_W-1:0] credit;

  logic [N_ITEMS-1:0]  afford;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;
  logic                at_max;
  logic [31:0]         credit_wide;

  // Per-item affordability and the price of the requested item. The request
  // is only honoured when exactly one item is selected and the current credit
  // covers that item's price, so a multi-hot request can never dispense.
  always_comb begin
    afford    = '0;
    sel_price = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      afford[i] = (credit >= PRICES[i*CREDIT_W +: CREDIT_W]);
      if (i_sel[i]) begin
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    sel_ok = $onehot(i_sel) && (|(i_sel & afford));
    at_max = (credit == MAX_C);
  end

  // Main controller. State, credit and the pulse outputs all move on the same
  // edge, so o_dispense and o_coin_ret line up exactly with the DISPENSE and
  // REFUND states. Pulse outputs default low every cycle and are raised only
  // when the next state calls for them. A coin is rejected whenever it cannot
  // be added to credit: outside IDLE/CREDIT, when a higher-priority refund or
  // sale wins the cycle, or at the credit ceiling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      credit        <= '0;
      o_dispense    <= '0;
      o_coin_ret    <= 1'b0;
      o_coin_reject <= 1'b0;
    end else begin
      o_dispense    <= '0;
      o_coin_ret    <= 1'b0;
      o_coin_reject <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_coin) begin
            state  <= S_CREDIT;
            credit <= ONE_C;
          end
        end
        S_CREDIT: begin
          if (i_refund) begin
            state         <= S_REFUND;
            o_coin_ret    <= 1'b1;
            o_coin_reject <= i_coin;
          end else if (sel_ok) begin
            state         <= S_DISPENSE;
            credit        <= credit - sel_price;
            o_dispense    <= i_sel;
            o_coin_reject <= i_coin;
          end else if (i_coin) begin
            if (at_max) begin
              o_coin_reject <= 1'b1;
            end else begin
              credit <= credit + ONE_C;
            end
          end
        end
        S_DISPENSE: begin
          o_coin_reject <= i_coin;
          if (credit == '0) begin
            state <= S_IDLE;
          end else if (AUTO_CHANGE) begin
            state      <= S_REFUND;
            o_coin_ret <= 1'b1;
          end else begin
            state <= S_CREDIT;
          end
        end
        S_REFUND: begin
          o_coin_reject <= i_coin;
          if (credit <= ONE_C) begin
            state  <= S_IDLE;
            credit <= '0;
          end else begin
            credit     <= credit - ONE_C;
            o_coin_ret <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          credit <= '0;
        end
      endcase
    end
  end

  // Status outputs decoded straight from the registers.
  always_comb begin
    credit_wide = 32'(credit);
    o_credit    = credit;
    o_bcd_tens  = 4'(credit_wide / 32'd10);
    o_bcd_ones  = 4'(credit_wide % 32'd10);
    o_busy      = (state == S_DISPENSE) || (state == S_REFUND);
    o_led_avail = (state == S_CREDIT) ? afford : '0;
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param
//
// Directed bench for vending_machine_param. Two instances share the stimulus:
// dut uses the default parameters, dut_ac enables AUTO_CHANGE. Each scenario
// task resets, drives its vectors and compares against hand-computed values.
// Default prices: item0=1, item1=1, item2=2, item3=3, MAX_CREDIT=9.

module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_coin = 1'b0;
  logic [3:0] i_sel = 4'b0000;
  logic       i_refund = 1'b0;

  logic [3:0] led_avail, dispense, bcd_tens, bcd_ones, credit;
  logic       coin_ret, coin_reject, busy;

  logic [3:0] ac_led_avail, ac_dispense, ac_bcd_tens, ac_bcd_ones, ac_credit;
  logic       ac_coin_ret, ac_coin_reject, ac_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vending_machine_param dut (
    .clk(clk), .rst(rst), .i_coin(i_coin), .i_sel(i_sel), .i_refund(i_refund),
    .o_led_avail(led_avail), .o_dispense(dispense), .o_coin_ret(coin_ret),
    .o_coin_reject(coin_reject), .o_credit(credit), .o_bcd_tens(bcd_tens),
    .o_bcd_ones(bcd_ones), .o_busy(busy)
  );

  vending_machine_param #(.AUTO_CHANGE(1'b1)) dut_ac (
    .clk(clk), .rst(rst), .i_coin(i_coin), .i_sel(i_sel), .i_refund(i_refund),
    .o_led_avail(ac_led_avail), .o_dispense(ac_dispense), .o_coin_ret(ac_coin_ret),
    .o_coin_reject(ac_coin_reject), .o_credit(ac_credit), .o_bcd_tens(ac_bcd_tens),
    .o_bcd_ones(ac_bcd_ones), .o_busy(ac_busy)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_coin = 1'b0; i_sel = 4'b0000; i_refund = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic insert_coins(input int n);
    for (int k = 0; k < n; k++) begin
      i_coin = 1'b1;
      tick();
    end
    i_coin = 1'b0;
  endtask

  // Reset held while coins arrive must leave everything cleared.
  task automatic test_reset();
    rst = 1'b1; i_coin = 1'b1;
    tick(); tick();
    i_coin = 1'b0; rst = 1'b0;
    vectors++; if (credit !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_credit: got %0d expected 0", credit); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (led_avail !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_led: got %b expected 0000", led_avail); end
    vectors++; if (dispense !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_dispense: got %b expected 0000", dispense); end
    vectors++; if (coin_ret !== 1'b0 || coin_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pulses: got ret=%b rej=%b expected 0 0", coin_ret, coin_reject); end
    vectors++; if (bcd_tens !== 4'd0 || bcd_ones !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_bcd: got %0d%0d expected 00", bcd_tens, bcd_ones); end
  endtask

  // In IDLE, select and refund are ignored.
  task automatic test_idle_ignore();
    do_reset();
    i_sel = 4'b0001; i_refund = 1'b1;
    tick();
    i_sel = 4'b0000; i_refund = 1'b0;
    vectors++; if (credit !== 4'd0 || busy !== 1'b0 || dispense !== 4'b0000 || coin_ret !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_ignore: got credit=%0d busy=%b disp=%b ret=%b expected 0 0 0000 0", credit, busy, dispense, coin_ret); end
  endtask

  // Three coins buy item3 (price 3) and leave zero credit.
  task automatic test_dispense_item3();
    do_reset();
    insert_coins(3);
    vectors++; if (credit !== 4'd3) begin miscompares++; $display("[TB] FAIL d3_credit: got %0d expected 3", credit); end
    vectors++; if (led_avail !== 4'b1111) begin miscompares++; $display("[TB] FAIL d3_led: got %b expected 1111", led_avail); end
    i_sel = 4'b1000;
    tick();
    i_sel = 4'b0000;
    vectors++; if (dispense !== 4'b1000) begin miscompares++; $display("[TB] FAIL d3_dispense: got %b expected 1000", dispense); end
    vectors++; if (credit !== 4'd0 || busy !== 1'b1 || led_avail !== 4'b0000) begin miscompares++; $display("[TB] FAIL d3_in_dispense: got credit=%0d busy=%b led=%b expected 0 1 0000", credit, busy, led_avail); end
    tick();
    vectors++; if (dispense !== 4'b0000) begin miscompares++; $display("[TB] FAIL d3_pulse_width: got %b expected 0000", dispense); end
    vectors++; if (busy !== 1'b0 || led_avail !== 4'b0000 || credit !== 4'd0) begin miscompares++; $display("[TB] FAIL d3_idle: got busy=%b led=%b credit=%0d expected 0 0000 0", busy, led_avail, credit); end
  endtask

  // Five coins, buy item2 (price 2), then refund the remaining three.
  task automatic test_refund();
    int pulses;
    do_reset();
    insert_coins(5);
    i_sel = 4'b0100;
    tick();
    i_sel = 4'b0000;
    vectors++; if (dispense !== 4'b0100 || credit !== 4'd3) begin miscompares++; $display("[TB] FAIL rf_dispense: got disp=%b credit=%0d expected 0100 3", dispense, credit); end
    tick();
    vectors++; if (busy !== 1'b0 || credit !== 4'd3 || led_avail !== 4'b1111) begin miscompares++; $display("[TB] FAIL rf_back_to_credit: got busy=%b credit=%0d led=%b expected 0 3 1111", busy, credit, led_avail); end
    i_refund = 1'b1;
    tick();
    i_refund = 1'b0;
    vectors++; if (coin_ret !== 1'b1 || credit !== 4'd3 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rf_enter: got ret=%b credit=%0d busy=%b expected 1 3 1", coin_ret, credit, busy); end
    pulses = (coin_ret === 1'b1) ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (coin_ret !== 1'b1) break;
      pulses++;
    end
    vectors++; if (pulses !== 3) begin miscompares++; $display("[TB] FAIL rf_pulses: got %0d expected 3", pulses); end
    vectors++; if (credit !== 4'd0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rf_idle: got credit=%0d busy=%b expected 0 0", credit, busy); end
  endtask

  // Ten coins in a row: credit saturates at 9 and the tenth is rejected.
  task automatic test_max_credit();
    do_reset();
    insert_coins(9);
    vectors++; if (credit !== 4'd9 || coin_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL mx_nine: got credit=%0d rej=%b expected 9 0", credit, coin_reject); end
    i_coin = 1'b1;
    tick();
    i_coin = 1'b0;
    vectors++; if (coin_reject !== 1'b1 || credit !== 4'd9) begin miscompares++; $display("[TB] FAIL mx_reject: got rej=%b credit=%0d expected 1 9", coin_reject, credit); end
    vectors++; if (bcd_tens !== 4'd0 || bcd_ones !== 4'd9) begin miscompares++; $display("[TB] FAIL mx_bcd: got %0d/%0d expected 0/9", bcd_tens, bcd_ones); end
    tick();
    vectors++; if (coin_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL mx_reject_width: got %b expected 0", coin_reject); end
  endtask

  // Unaffordable and multi-hot requests are ignored; a sale beats a coin.
  task automatic test_invalid_sel();
    do_reset();
    insert_coins(1);
    i_sel = 4'b0100;
    tick();
    vectors++; if (credit !== 4'd1 || dispense !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL iv_unaffordable: got credit=%0d disp=%b busy=%b expected 1 0000 0", credit, dispense, busy); end
    vectors++; if (led_avail !== 4'b0011) begin miscompares++; $display("[TB] FAIL iv_led: got %b expected 0011", led_avail); end
    i_sel = 4'b0011;
    tick();
    vectors++; if (credit !== 4'd1 || dispense !== 4'b0000) begin miscompares++; $display("[TB] FAIL iv_multihot: got credit=%0d disp=%b expected 1 0000", credit, dispense); end
    i_sel = 4'b0001; i_coin = 1'b1;
    tick();
    i_sel = 4'b0000; i_coin = 1'b0;
    vectors++; if (dispense !== 4'b0001 || credit !== 4'd0 || coin_reject !== 1'b1) begin miscompares++; $display("[TB] FAIL iv_sale_vs_coin: got disp=%b credit=%0d rej=%b expected 0001 0 1", dispense, credit, coin_reject); end
    tick();
    vectors++; if (busy !== 1'b0 || credit !== 4'd0 || coin_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL iv_idle: got busy=%b credit=%0d rej=%b expected 0 0 0", busy, credit, coin_reject); end
    // An ignored request does not block a coin arriving in the same cycle.
    insert_coins(1);
    i_sel = 4'b0110; i_coin = 1'b1;
    tick();
    i_sel = 4'b0000; i_coin = 1'b0;
    vectors++; if (credit !== 4'd2 || dispense !== 4'b0000 || coin_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL iv_coin_with_bad_sel: got credit=%0d disp=%b rej=%b expected 2 0000 0", credit, dispense, coin_reject); end
  endtask

  // AUTO_CHANGE instance: sale followed by automatic refund of the rest.
  task automatic test_auto_change();
    int pulses;
    do_reset();
    insert_coins(4);
    vectors++; if (ac_credit !== 4'd4 || ac_led_avail !== 4'b1111) begin miscompares++; $display("[TB] FAIL ac_credit: got credit=%0d led=%b expected 4 1111", ac_credit, ac_led_avail); end
    i_sel = 4'b0001;
    tick();
    i_sel = 4'b0000;
    vectors++; if (ac_dispense !== 4'b0001 || ac_credit !== 4'd3 || ac_coin_ret !== 1'b0) begin miscompares++; $display("[TB] FAIL ac_dispense: got disp=%b credit=%0d ret=%b expected 0001 3 0", ac_dispense, ac_credit, ac_coin_ret); end
    tick();
    vectors++; if (ac_coin_ret !== 1'b1 || ac_credit !== 4'd3 || ac_busy !== 1'b1 || ac_dispense !== 4'b0000) begin miscompares++; $display("[TB] FAIL ac_refund_start: got ret=%b credit=%0d busy=%b disp=%b expected 1 3 1 0000", ac_coin_ret, ac_credit, ac_busy, ac_dispense); end
    pulses = (ac_coin_ret === 1'b1) ? 1 : 0;
    i_coin = 1'b1;
    tick();
    i_coin = 1'b0;
    vectors++; if (ac_coin_reject !== 1'b1 || ac_credit !== 4'd2) begin miscompares++; $display("[TB] FAIL ac_coin_in_refund: got rej=%b credit=%0d expected 1 2", ac_coin_reject, ac_credit); end
    if (ac_coin_ret === 1'b1) pulses++;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ac_coin_ret !== 1'b1) break;
      pulses++;
    end
    vectors++; if (pulses !== 3) begin miscompares++; $display("[TB] FAIL ac_pulses: got %0d expected 3", pulses); end
    vectors++; if (ac_credit !== 4'd0 || ac_busy !== 1'b0 || ac_bcd_tens !== 4'd0 || ac_bcd_ones !== 4'd0) begin miscompares++; $display("[TB] FAIL ac_idle: got credit=%0d busy=%b bcd=%0d%0d expected 0 0 00", ac_credit, ac_busy, ac_bcd_tens, ac_bcd_ones); end
  endtask

  // Reset in the middle of a refund drops the remaining credit silently.
  task automatic test_reset_mid_refund();
    do_reset();
    insert_coins(7);
    i_refund = 1'b1;
    tick();
    i_refund = 1'b0;
    tick(); tick();
    vectors++; if (credit !== 4'd5 || coin_ret !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_before: got credit=%0d ret=%b expected 5 1", credit, coin_ret); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (credit !== 4'd0 || coin_ret !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_after: got credit=%0d ret=%b busy=%b expected 0 0 0", credit, coin_ret, busy); end
    tick();
    vectors++; if (coin_ret !== 1'b0 || credit !== 4'd0) begin miscompares++; $display("[TB] FAIL mr_no_resume: got ret=%b credit=%0d expected 0 0", coin_ret, credit); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_dispense_item3();
    test_refund();
    test_max_credit();
    test_invalid_sel();
    test_auto_change();
    test_reset_mid_refund();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
